universal_counter_reg: RTL and testbench

//  Parametrised universal register: parallel load, bounded up/down count with programmable

---
 rtl/universal_counter_reg_pkg.sv | 22 ++
 rtl/universal_counter_reg_if.sv | 30 +++
 rtl/universal_counter_reg_bound_step.sv | 45 ++++
 rtl/universal_counter_reg.sv | 105 ++++++++++
 tb/tb_universal_counter_reg.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/universal_counter_reg_pkg.sv
// Shared op codes and control-state encoding for the universal counter register.
package urc_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } urc_state_e;

  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/universal_counter_reg_if.sv
// Control/data bundle of the universal counter register; master drives ops, slave is the register.
interface urc_if #(
  parameter int N = 8
) ();

  logic         CLR;
  logic         EN;
  logic [2:0]   OP;
  logic         SAT;
  logic [N-1:0] D;
  logic [N-1:0] LO;
  logic [N-1:0] HI;
  logic [N-1:0] STEP;
  logic         SI;
  logic [N-1:0] Q;
  logic         SO;
  logic         TC;
  logic         BUSY;

  modport master (
    output CLR, EN, OP, SAT, D, LO, HI, STEP, SI,
    input  Q, SO, TC, BUSY
  );

  modport slave (
    input  CLR, EN, OP, SAT, D, LO, HI, STEP, SI,
    output Q, SO, TC, BUSY
  );

endinterface

// File: rtl/universal_counter_reg_bound_step.sv
// Combinational bounded step: next count value and window-hit flag; zero latency.
// No flow control; result is valid whenever the inputs are.
module urc_bound_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_step,
  input  logic [N-1:0] i_lo,
  input  logic [N-1:0] i_hi,
  input  logic         i_sat,
  input  logic         i_dn,
  output logic [N-1:0] o_nxt,
  output logic         o_hit
);

  logic [N:0] w_sum;
  logic [N:0] w_room;
  logic       w_miscfg;
  logic       w_inc_hit;
  logic       w_dec_hit;

  // One extra bit keeps the compares free of wrap-around.
  assign w_sum     = {1'b0, i_q} + {1'b0, i_step};
  assign w_room    = {1'b0, i_q} - {1'b0, i_lo};
  assign w_miscfg  = (i_lo > i_hi);

  assign w_inc_hit = w_miscfg || (i_q >= i_hi) || (w_sum > {1'b0, i_hi});
  // w_room is only meaningful when Q > LO, which the middle term guarantees.
  assign w_dec_hit = w_miscfg || (i_q <= i_lo) || ({1'b0, i_step} > w_room);

  always_comb begin
    o_hit = 1'b0;
    o_nxt = i_q;
    if (i_dn) begin
      o_hit = w_dec_hit;
      if (w_dec_hit) o_nxt = i_sat ? i_lo : i_hi;
      else           o_nxt = i_q - i_step;
    end else begin
      o_hit = w_inc_hit;
      if (w_inc_hit) o_nxt = i_sat ? i_hi : i_lo;
      else           o_nxt = w_sum[N-1:0];
    end
  end

endmodule

// File: rtl/universal_counter_reg.sv
// Universal register: load, bounded count, shift/rotate; all outputs registered, latency 1 cycle.
// No backpressure: a new op is accepted on every enabled clock edge.
module universal_counter_reg
  import urc_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic C,
  input  logic RN,
  urc_if.slave bus
);

  logic [N-1:0] r_q;
  logic         r_so;
  logic         r_tc;
  urc_state_e   r_st;

  logic [N-1:0] w_q_nxt;
  logic         w_so_nxt;
  logic         w_tc_nxt;
  urc_state_e   w_st_nxt;

  logic         w_dn;
  logic [N-1:0] w_cnt_nxt;
  logic         w_hit;

  assign w_dn = (bus.OP == OP_DEC);

  urc_bound_step #(.N(N)) u_bound_step (
    .i_q    (r_q),
    .i_step (bus.STEP),
    .i_lo   (bus.LO),
    .i_hi   (bus.HI),
    .i_sat  (bus.SAT),
    .i_dn   (w_dn),
    .o_nxt  (w_cnt_nxt),
    .o_hit  (w_hit)
  );

  always_comb begin
    w_q_nxt  = r_q;
    w_so_nxt = r_so;
    w_tc_nxt = 1'b0;
    if (bus.CLR) begin
      w_q_nxt  = bus.LO;
      w_so_nxt = 1'b0;
    end else if (bus.EN) begin
      case (bus.OP)
        OP_HOLD: ;
        OP_LOAD: w_q_nxt = bus.D;
        OP_INC, OP_DEC: begin
          w_q_nxt  = w_cnt_nxt;
          w_tc_nxt = w_hit;
        end
        OP_SHL: begin
          w_q_nxt  = {r_q[N-2:0], bus.SI};
          w_so_nxt = r_q[N-1];
        end
        OP_SHR: begin
          w_q_nxt  = {bus.SI, r_q[N-1:1]};
          w_so_nxt = r_q[0];
        end
        OP_ROL: begin
          w_q_nxt  = {r_q[N-2:0], r_q[N-1]};
          w_so_nxt = r_q[N-1];
        end
        OP_ROR: begin
          w_q_nxt  = {r_q[0], r_q[N-1:1]};
          w_so_nxt = r_q[0];
        end
      endcase
    end
  end

  // Run tracker: stays in RUN only across uninterrupted INC/DEC ops; EN=0 freezes it.
  always_comb begin
    w_st_nxt = r_st;
    if (bus.CLR) begin
      w_st_nxt = ST_IDLE;
    end else if (bus.EN) begin
      w_st_nxt = is_count_op(bus.OP) ? ST_RUN : ST_IDLE;
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      r_q  <= INIT;
      r_so <= 1'b0;
      r_tc <= 1'b0;
      r_st <= ST_IDLE;
    end else begin
      r_q  <= w_q_nxt;
      r_so <= w_so_nxt;
      r_tc <= w_tc_nxt;
      r_st <= w_st_nxt;
    end
  end

  assign bus.Q    = r_q;
  assign bus.SO   = r_so;
  assign bus.TC   = r_tc;
  assign bus.BUSY = (r_st == ST_RUN);

endmodule

// File: tb/tb_universal_counter_reg.sv
// Directed vectors for universal_counter_reg (N=4, INIT=10) checked through an expected-response queue.
module tb_universal_counter_reg;
  import urc_pkg::*;

  localparam int N = 4;

  typedef struct {
    string      nm;
    logic [3:0] q;
    logic       so;
    logic       tc;
    logic       busy;
  } exp_t;

  logic C;
  logic RN;
  urc_if #(.N(N)) bus ();

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  universal_counter_reg #(.N(N), .INIT(4'd10)) dut (
    .C   (C),
    .RN  (RN),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Monitor: every clock edge makes outputs new; compare one queued expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge C);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.Q !== e.q || bus.SO !== e.so || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
          n_err++;
          $display("FAIL %s: got Q=%0d SO=%b TC=%b BUSY=%b, want Q=%0d SO=%b TC=%b BUSY=%b",
                   e.nm, bus.Q, bus.SO, bus.TC, bus.BUSY, e.q, e.so, e.tc, e.busy);
        end
      end
    end
  end

  task automatic vec(input string nm, input bit clr, input bit en, input logic [2:0] op,
                     input bit sat, input int d, input int lo, input int hi, input int step,
                     input bit si, input int eq, input bit eso, input bit etc, input bit ebusy);
    exp_t e;
    @(negedge C);
    bus.CLR  = clr;
    bus.EN   = en;
    bus.OP   = op;
    bus.SAT  = sat;
    bus.D    = 4'(d);
    bus.LO   = 4'(lo);
    bus.HI   = 4'(hi);
    bus.STEP = 4'(step);
    bus.SI   = si;
    e.nm   = nm;
    e.q    = 4'(eq);
    e.so   = eso;
    e.tc   = etc;
    e.busy = ebusy;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    @(negedge C);
    bus.CLR = 1'b0;
    bus.EN  = 1'b0;
    budget  = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge C);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending responses, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string nm);
    n_vec++;
    if (bus.Q !== 4'd10 || bus.SO !== 1'b0 || bus.TC !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got Q=%0d SO=%b TC=%b BUSY=%b, want Q=10 SO=0 TC=0 BUSY=0",
               nm, bus.Q, bus.SO, bus.TC, bus.BUSY);
    end
  endtask

  initial begin
    bus.CLR = 0; bus.EN = 0; bus.OP = OP_HOLD; bus.SAT = 0;
    bus.D = '0; bus.LO = '0; bus.HI = '0; bus.STEP = '0; bus.SI = 0;
    RN = 1'b1;
    #1 RN = 1'b0;
    #1 check_reset("reset_initial");
    @(negedge C);
    @(negedge C);
    RN = 1'b1;

    //  name            clr en op       sat d   lo hi  st si   q  so tc busy
    vec("inc_a",        0, 1, OP_INC,  0,  0,  0, 15, 1, 0,  11, 0, 0, 1);
    vec("inc_b",        0, 1, OP_INC,  0,  0,  0, 15, 1, 0,  12, 0, 0, 1);
    drain();
    #3 RN = 1'b0;
    #1 check_reset("reset_mid_run");
    @(negedge C);
    RN = 1'b1;

    vec("t2_load5",     0, 1, OP_LOAD, 0,  5,  2,  9, 3, 0,   5, 0, 0, 0);
    vec("t2_inc8",      0, 1, OP_INC,  0,  0,  2,  9, 3, 0,   8, 0, 0, 1);
    vec("t2_wrap2",     0, 1, OP_INC,  0,  0,  2,  9, 3, 0,   2, 0, 1, 1);
    vec("t2_inc5",      0, 1, OP_INC,  0,  0,  2,  9, 3, 0,   5, 0, 0, 1);

    vec("t3_load6",     0, 1, OP_LOAD, 1,  6,  3, 12, 2, 0,   6, 0, 0, 0);
    vec("t3_dec4",      0, 1, OP_DEC,  1,  0,  3, 12, 2, 0,   4, 0, 0, 1);
    vec("t3_sat3",      0, 1, OP_DEC,  1,  0,  3, 12, 2, 0,   3, 0, 1, 1);
    vec("t3_sat3_again",0, 1, OP_DEC,  1,  0,  3, 12, 2, 0,   3, 0, 1, 1);

    vec("t4_load9",     0, 1, OP_LOAD, 0,  9,  0, 15, 1, 0,   9, 0, 0, 0);
    vec("t4_shl",       0, 1, OP_SHL,  0,  0,  0, 15, 1, 0,   2, 1, 0, 0);
    vec("t4_shr",       0, 1, OP_SHR,  0,  0,  0, 15, 1, 1,   9, 0, 0, 0);
    vec("t4_ror",       0, 1, OP_ROR,  0,  0,  0, 15, 1, 0,  12, 1, 0, 0);
    vec("t4_rol",       0, 1, OP_ROL,  0,  0,  0, 15, 1, 0,   9, 1, 0, 0);
    vec("t4_hold_so",   0, 1, OP_HOLD, 0,  0,  0, 15, 1, 0,   9, 1, 0, 0);

    vec("t5_clr_prio",  1, 0, OP_LOAD, 0,  7,  3, 15, 1, 0,   3, 0, 0, 0);
    vec("t5_en0_inc",   0, 0, OP_INC,  0,  7,  3, 15, 1, 0,   3, 0, 0, 0);
    vec("en0_pre_dec",  0, 1, OP_DEC,  1,  0,  3, 12, 2, 0,   3, 0, 1, 1);
    vec("en0_tc_clear", 0, 0, OP_DEC,  1,  0,  3, 12, 2, 0,   3, 0, 0, 1);
    vec("hold_idle",    0, 1, OP_HOLD, 1,  0,  3, 12, 2, 0,   3, 0, 0, 0);

    vec("t6_load15",    0, 1, OP_LOAD, 0, 15,  9,  4, 1, 0,  15, 0, 0, 0);
    vec("t6_inc_lo",    0, 1, OP_INC,  0,  0,  9,  4, 1, 0,   9, 0, 1, 1);
    vec("t6_dec_hi",    0, 1, OP_DEC,  0,  0,  9,  4, 1, 0,   4, 0, 1, 1);

    vec("step0_inc",    0, 1, OP_INC,  0,  0,  0, 15, 0, 0,   4, 0, 0, 1);
    vec("ovf_load14",   0, 1, OP_LOAD, 0, 14,  0, 15, 3, 0,  14, 0, 0, 0);
    vec("ovf_inc_wrap", 0, 1, OP_INC,  0,  0,  0, 15, 3, 0,   0, 0, 1, 1);
    vec("udf_load1",    0, 1, OP_LOAD, 0,  1,  0, 15, 3, 0,   1, 0, 0, 0);
    vec("udf_dec_wrap", 0, 1, OP_DEC,  0,  0,  0, 15, 3, 0,  15, 0, 1, 1);
    vec("sat_hi_inc",   0, 1, OP_INC,  1,  0,  0, 15, 1, 0,  15, 0, 1, 1);
    vec("shl_so",       0, 1, OP_SHL,  0,  0,  0, 15, 1, 0,  14, 1, 0, 0);
    vec("clr_so",       1, 1, OP_SHL,  0,  0,  5, 15, 1, 0,   5, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
